// File: rtl/sandbox_verdict_if.sv
`default_nettype none
// ============================================================================
// Module      : sandbox_verdict_if
// Description : Status bundle between the two-copy ridecore sandbox and its
//               verdict stage. The sandbox side (master) drives the per-cycle
//               status; the verdict side (slave) returns the FSM state, the
//               sticky verdict flags and the per-copy commit counts.
//               CNT_W must match the CNT_W of the attached sandbox_verdict.
// Ports       : deviation_i, invalid_program_i, finish_{1,2}_i,
//               stall_{1,2}_i, prmiss_{1,2}_i, comnum_{1,2}_i  (to verdict)
//               state_o, leak_o, filtered_o, timeout_o, deadlock_o,
//               protocol_err_o, done_o, commits_{1,2}_o       (from verdict)
// Revision    : 1.0 - initial release
// ============================================================================
interface sandbox_verdict_if #(
  parameter int CNT_W = 16
);
  logic             deviation_i;
  logic             invalid_program_i;
  logic             finish_1_i;
  logic             finish_2_i;
  logic             stall_1_i;
  logic             stall_2_i;
  logic             prmiss_1_i;
  logic             prmiss_2_i;
  logic [1:0]       comnum_1_i;
  logic [1:0]       comnum_2_i;

  logic [1:0]       state_o;
  logic             leak_o;
  logic             filtered_o;
  logic             timeout_o;
  logic             deadlock_o;
  logic             protocol_err_o;
  logic             done_o;
  logic [CNT_W-1:0] commits_1_o;
  logic [CNT_W-1:0] commits_2_o;

  // Sandbox side: produces status, observes the verdict.
  modport master (
    output deviation_i, invalid_program_i, finish_1_i, finish_2_i,
           stall_1_i, stall_2_i, prmiss_1_i, prmiss_2_i,
           comnum_1_i, comnum_2_i,
    input  state_o, leak_o, filtered_o, timeout_o, deadlock_o,
           protocol_err_o, done_o, commits_1_o, commits_2_o
  );

  // Verdict side: consumes status, produces the verdict.
  modport slave (
    input  deviation_i, invalid_program_i, finish_1_i, finish_2_i,
           stall_1_i, stall_2_i, prmiss_1_i, prmiss_2_i,
           comnum_1_i, comnum_2_i,
    output state_o, leak_o, filtered_o, timeout_o, deadlock_o,
           protocol_err_o, done_o, commits_1_o, commits_2_o
  );
endinterface
`default_nettype wire

// File: rtl/sandbox_verdict.sv
`default_nettype none
// ============================================================================
// Module      : sandbox_verdict
// Description : Verdict stage for the two-copy ridecore sandbox. A
//               RUN -> DRAIN -> DONE state machine folds the sandbox status
//               into one sticky verdict (leak / filtered / timeout /
//               deadlock), keeps saturating per-copy commit counters and
//               flags illegal status-stream behaviour.
// Ports       : clk  - single clock
//               rst  - synchronous, active-high reset
//               bus  - sandbox_verdict_if.slave (status in, verdict out)
// Parameters  : CNT_W     - commit counter width (>= 2)
//               DRAIN_MAX - DRAIN cycles allowed before timeout
//               HANG_MAX  - consecutive commit-free RUN cycles allowed
// Revision    : 1.0 - initial release
// ============================================================================
module sandbox_verdict #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_MAX = 64,
  parameter int HANG_MAX  = 256
) (
  input  logic             clk,
  input  logic             rst,
  sandbox_verdict_if.slave bus
);

  // Internal cycle counters only ever reach MAX-1 before leaving the state,
  // so they are sized to hold exactly that range.
  localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam int HANG_W  = (HANG_MAX > 1) ? $clog2(HANG_MAX) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
  localparam logic [HANG_W-1:0]  HANG_LAST  = HANG_W'(HANG_MAX - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t             state;
  logic               leak;
  logic               filtered;
  logic               timeout;
  logic               deadlock;
  logic               protocol_err;
  logic               done;
  logic [CNT_W-1:0]   commits_1;
  logic [CNT_W-1:0]   commits_2;
  logic [HANG_W-1:0]  hang_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               fin_1;
  logic               fin_2;

  // Commits that actually count this cycle: a stalled copy contributes
  // nothing and the illegal encoding 3 is treated as zero.
  logic       illegal_1;
  logic       illegal_2;
  logic [1:0] count_1;
  logic [1:0] count_2;
  logic       any_commit;
  logic       both_stall;
  logic       any_prmiss;
  logic       drained;

  assign illegal_1  = (bus.comnum_1_i == 2'd3);
  assign illegal_2  = (bus.comnum_2_i == 2'd3);
  assign count_1    = (!bus.stall_1_i && !illegal_1) ? bus.comnum_1_i : 2'd0;
  assign count_2    = (!bus.stall_2_i && !illegal_2) ? bus.comnum_2_i : 2'd0;
  assign any_commit = (count_1 != 2'd0) || (count_2 != 2'd0);
  assign both_stall = bus.stall_1_i && bus.stall_2_i;
  assign any_prmiss = bus.prmiss_1_i || bus.prmiss_2_i;
  // A finish pulse counts in the cycle it arrives, not only once latched.
  assign drained    = (fin_1 || bus.finish_1_i) && (fin_2 || bus.finish_2_i);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      leak         <= 1'b0;
      filtered     <= 1'b0;
      timeout      <= 1'b0;
      deadlock     <= 1'b0;
      protocol_err <= 1'b0;
      done         <= 1'b0;
      commits_1    <= '0;
      commits_2    <= '0;
      hang_cnt     <= '0;
      drain_cnt    <= '0;
      fin_1        <= 1'b0;
      fin_2        <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          commits_1 <= sat_add(commits_1, count_1);
          commits_2 <= sat_add(commits_2, count_2);
          // Drain completion is meaningless before a deviation was seen.
          if (illegal_1 || illegal_2 || bus.finish_1_i || bus.finish_2_i)
            protocol_err <= 1'b1;

          if (bus.invalid_program_i) begin
            filtered <= 1'b1;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else if (both_stall) begin
            deadlock <= 1'b1;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else if (!any_commit && (hang_cnt == HANG_LAST)) begin
            deadlock <= 1'b1;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            hang_cnt <= any_commit ? '0 : hang_cnt + HANG_W'(1);
            if (bus.deviation_i) begin
              drain_cnt <= '0;
              fin_1     <= 1'b0;
              fin_2     <= 1'b0;
              state     <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          commits_1 <= sat_add(commits_1, count_1);
          commits_2 <= sat_add(commits_2, count_2);
          // deviation_i is sticky upstream; seeing it low here is a fault.
          if (illegal_1 || illegal_2 || !bus.deviation_i)
            protocol_err <= 1'b1;
          fin_1 <= fin_1 | bus.finish_1_i;
          fin_2 <= fin_2 | bus.finish_2_i;
          // A mispredict rewinds the ROB tail, so the drain budget restarts.
          drain_cnt <= any_prmiss ? '0 : drain_cnt + DRAIN_W'(1);

          if (bus.invalid_program_i) begin
            filtered <= 1'b1;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else if (drained) begin
            leak  <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (both_stall) begin
            deadlock <= 1'b1;
            done     <= 1'b1;
            state    <= ST_DONE;
          end else if (!any_prmiss && (drain_cnt == DRAIN_LAST)) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Absorbing: everything holds until reset.
        end

        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.state_o        = state;
  assign bus.leak_o         = leak;
  assign bus.filtered_o     = filtered;
  assign bus.timeout_o      = timeout;
  assign bus.deadlock_o     = deadlock;
  assign bus.protocol_err_o = protocol_err;
  assign bus.done_o         = done;
  assign bus.commits_1_o    = commits_1;
  assign bus.commits_2_o    = commits_2;

endmodule
`default_nettype wire

// File: tb/tb_sandbox_verdict.sv
`default_nettype none
// ============================================================================
// Module      : tb_sandbox_verdict
// Description : Scoreboard bench for sandbox_verdict. Two instances: A with
//               default parameters, B with CNT_W=3, DRAIN_MAX=8, HANG_MAX=4.
//               Stimulus threads push (cycle, dut, field, value) expectations
//               into a queue; a negedge monitor pops and compares the ones
//               due in the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sandbox_verdict;

  localparam int F_STATE = 0, F_LEAK = 1, F_FILT = 2, F_TMO = 3, F_DLK = 4,
                 F_PERR  = 5, F_DONE = 6, F_C1   = 7, F_C2  = 8;

  typedef struct {
    int          cyc;
    int          dut;
    int          fld;
    int unsigned val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   t0 = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];
  int          mi;
  int unsigned mgot;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sandbox_verdict_if #(.CNT_W(16)) bus_a ();
  sandbox_verdict_if #(.CNT_W(3))  bus_b ();

  sandbox_verdict #(.CNT_W(16), .DRAIN_MAX(64), .HANG_MAX(256)) u_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  sandbox_verdict #(.CNT_W(3), .DRAIN_MAX(8), .HANG_MAX(4)) u_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  function automatic int unsigned rd(input int dut, input int fld);
    if (dut == 0) begin
      case (fld)
        F_STATE: return int'(bus_a.state_o);
        F_LEAK:  return int'(bus_a.leak_o);
        F_FILT:  return int'(bus_a.filtered_o);
        F_TMO:   return int'(bus_a.timeout_o);
        F_DLK:   return int'(bus_a.deadlock_o);
        F_PERR:  return int'(bus_a.protocol_err_o);
        F_DONE:  return int'(bus_a.done_o);
        F_C1:    return int'(bus_a.commits_1_o);
        default: return int'(bus_a.commits_2_o);
      endcase
    end else begin
      case (fld)
        F_STATE: return int'(bus_b.state_o);
        F_LEAK:  return int'(bus_b.leak_o);
        F_FILT:  return int'(bus_b.filtered_o);
        F_TMO:   return int'(bus_b.timeout_o);
        F_DLK:   return int'(bus_b.deadlock_o);
        F_PERR:  return int'(bus_b.protocol_err_o);
        F_DONE:  return int'(bus_b.done_o);
        F_C1:    return int'(bus_b.commits_1_o);
        default: return int'(bus_b.commits_2_o);
      endcase
    end
  endfunction

  // Monitor: compare every expectation due now; anything overdue is a miss.
  always @(negedge clk) begin
    mi = 0;
    while (mi < sbq.size()) begin
      if (sbq[mi].cyc == cyc) begin
        mgot = rd(sbq[mi].dut, sbq[mi].fld);
        n_cmp++;
        if (mgot !== sbq[mi].val) begin
          n_bad++;
          $display("FAIL %s (dut %0d, cycle %0d): got %0d expected %0d",
                   sbq[mi].name, sbq[mi].dut, cyc, mgot, sbq[mi].val);
        end
        sbq.delete(mi);
      end else if (sbq[mi].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s (dut %0d): expectation for cycle %0d never checked",
                 sbq[mi].name, sbq[mi].dut, sbq[mi].cyc);
        sbq.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dut, input int rel, input int fld,
                           input int unsigned val, input string name);
    exp_t e;
    e.cyc  = t0 + rel;
    e.dut  = dut;
    e.fld  = fld;
    e.val  = val;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic drive(input int dut, input logic dev, input logic inv,
                       input logic f1, input logic f2, input logic s1,
                       input logic s2, input logic p1, input logic p2,
                       input logic [1:0] c1, input logic [1:0] c2);
    if (dut == 0) begin
      bus_a.deviation_i = dev;  bus_a.invalid_program_i = inv;
      bus_a.finish_1_i  = f1;   bus_a.finish_2_i = f2;
      bus_a.stall_1_i   = s1;   bus_a.stall_2_i  = s2;
      bus_a.prmiss_1_i  = p1;   bus_a.prmiss_2_i = p2;
      bus_a.comnum_1_i  = c1;   bus_a.comnum_2_i = c2;
    end else begin
      bus_b.deviation_i = dev;  bus_b.invalid_program_i = inv;
      bus_b.finish_1_i  = f1;   bus_b.finish_2_i = f2;
      bus_b.stall_1_i   = s1;   bus_b.stall_2_i  = s2;
      bus_b.prmiss_1_i  = p1;   bus_b.prmiss_2_i = p2;
      bus_b.comnum_1_i  = c1;   bus_b.comnum_2_i = c2;
    end
  endtask

  // Reset one instance with idle inputs and check the reset state.
  task automatic reset_dut(input int dut);
    t0 = cyc;
    expect_at(dut, 1, F_STATE, 0, "reset_state");
    expect_at(dut, 1, F_LEAK,  0, "reset_leak");
    expect_at(dut, 1, F_DLK,   0, "reset_deadlock");
    expect_at(dut, 1, F_PERR,  0, "reset_perr");
    expect_at(dut, 1, F_DONE,  0, "reset_done");
    expect_at(dut, 1, F_C1,    0, "reset_commits_1");
    drive(dut, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    if (dut == 0) rst_a = 1'b1; else rst_b = 1'b1;
    tick();
    if (dut == 0) rst_a = 1'b0; else rst_b = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
    tick();
    tick();

    // A1: clean leak. deviation at 10, finish_1 at 14, finish_2 at 20.
    reset_dut(0);
    expect_at(0, 10, F_C1,    10, "leak_commits_before");
    expect_at(0, 11, F_STATE, 1,  "leak_enter_drain");
    expect_at(0, 20, F_LEAK,  0,  "leak_not_early");
    expect_at(0, 20, F_STATE, 1,  "leak_still_drain");
    expect_at(0, 21, F_LEAK,  1,  "leak_set");
    expect_at(0, 21, F_DONE,  1,  "leak_done");
    expect_at(0, 21, F_STATE, 2,  "leak_state_done");
    expect_at(0, 21, F_FILT,  0,  "leak_no_filtered");
    expect_at(0, 21, F_TMO,   0,  "leak_no_timeout");
    expect_at(0, 21, F_DLK,   0,  "leak_no_deadlock");
    expect_at(0, 21, F_PERR,  0,  "leak_no_perr");
    expect_at(0, 24, F_C1,    10, "done_commits_frozen");
    expect_at(0, 24, F_LEAK,  1,  "done_leak_held");
    for (int r = 0; r < 26; r++) begin
      drive(0, r >= 10, 0, r == 14, r == 20, 0, 0, 0, 0,
            (r < 10) ? 2'd1 : ((r >= 22) ? 2'd2 : 2'd0), 2'd0);
      tick();
    end

    // A2: invalid and both finishes in the same DRAIN cycle.
    reset_dut(0);
    expect_at(0, 1, F_STATE, 1, "filt_enter_drain");
    expect_at(0, 4, F_FILT,  1, "filt_set");
    expect_at(0, 4, F_LEAK,  0, "filt_beats_leak");
    expect_at(0, 4, F_DONE,  1, "filt_done");
    for (int r = 0; r < 6; r++) begin
      drive(0, 1, r >= 3, r == 3, r == 3, 0, 0, 0, 0, 2'd0, 2'd0);
      tick();
    end

    // A3: stalled copy ignored, then both stalled -> deadlock.
    reset_dut(0);
    expect_at(0, 1, F_C1,    2, "stall_c1_counts");
    expect_at(0, 2, F_C2,    0, "stall_c2_ignored");
    expect_at(0, 2, F_DLK,   0, "stall_single_ok");
    expect_at(0, 3, F_DLK,   1, "stall_both_deadlock");
    expect_at(0, 3, F_DONE,  1, "stall_done");
    expect_at(0, 3, F_C2,    0, "stall_c2_still_0");
    for (int r = 0; r < 5; r++) begin
      drive(0, 0, 0, 0, 0, r == 2, 1, 0, 0, (r == 0) ? 2'd2 : 2'd0, 2'd2);
      tick();
    end

    // A4: comnum 3 is a protocol error and counts nothing.
    reset_dut(0);
    expect_at(0, 1, F_PERR,  1, "c3_perr");
    expect_at(0, 1, F_C1,    0, "c3_no_count");
    expect_at(0, 2, F_C1,    1, "c3_then_count");
    expect_at(0, 2, F_PERR,  1, "c3_perr_sticky");
    expect_at(0, 2, F_STATE, 0, "c3_still_run");
    for (int r = 0; r < 4; r++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0,
            (r == 0) ? 2'd3 : ((r == 1) ? 2'd1 : 2'd0), 2'd0);
      tick();
    end

    // A5: reset in DRAIN with fin1 latched must clear fin1.
    reset_dut(0);
    expect_at(0, 3, F_STATE, 1, "rst_pre_drain");
    expect_at(0, 4, F_STATE, 0, "rst_mid_run");
    expect_at(0, 5, F_STATE, 1, "rst_redrain");
    expect_at(0, 7, F_LEAK,  0, "rst_fin1_cleared");
    expect_at(0, 7, F_STATE, 1, "rst_stay_drain");
    expect_at(0, 7, F_PERR,  0, "rst_no_perr");
    for (int r = 0; r < 9; r++) begin
      rst_a = (r == 3);
      drive(0, 1, 0, r == 2, r == 6, 0, 0, 0, 0, 2'd0, 2'd0);
      tick();
    end
    rst_a = 1'b0;

    // B1: DRAIN_MAX=8, prmiss at 5 restarts the drain budget.
    reset_dut(1);
    expect_at(1, 1,  F_STATE, 1, "tmo_enter_drain");
    expect_at(1, 9,  F_TMO,   0, "tmo_prmiss_delays");
    expect_at(1, 13, F_TMO,   0, "tmo_not_early");
    expect_at(1, 13, F_STATE, 1, "tmo_still_drain");
    expect_at(1, 14, F_TMO,   1, "tmo_set");
    expect_at(1, 14, F_DONE,  1, "tmo_done");
    expect_at(1, 14, F_LEAK,  0, "tmo_no_leak");
    expect_at(1, 14, F_DLK,   0, "tmo_no_deadlock");
    for (int r = 0; r < 16; r++) begin
      drive(1, 1, 0, 0, 0, 0, 0, r == 5, 0, 2'd0, 2'd0);
      tick();
    end

    // B2a: HANG_MAX=4, four commit-free cycles -> deadlock.
    reset_dut(1);
    expect_at(1, 3, F_DLK,   0, "hang_not_early");
    expect_at(1, 4, F_DLK,   1, "hang_deadlock");
    expect_at(1, 4, F_STATE, 2, "hang_done");
    for (int r = 0; r < 6; r++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      tick();
    end

    // B2b: a single commit at cycle 3 restarts the hang count.
    reset_dut(1);
    expect_at(1, 4, F_DLK, 0, "hang_commit_saves");
    expect_at(1, 4, F_C1,  1, "hang_commit_counted");
    expect_at(1, 7, F_DLK, 0, "hang_restart_not_early");
    expect_at(1, 8, F_DLK, 1, "hang_restart_deadlock");
    for (int r = 0; r < 10; r++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, (r == 3) ? 2'd1 : 2'd0, 2'd0);
      tick();
    end

    // B3: CNT_W=3 saturation, then finish in RUN flags a protocol error.
    reset_dut(1);
    expect_at(1, 3, F_C1,    6, "sat_c1_6");
    expect_at(1, 4, F_C1,    7, "sat_c1_7");
    expect_at(1, 5, F_C1,    7, "sat_c1_held");
    expect_at(1, 6, F_PERR,  0, "finrun_perr_clear");
    expect_at(1, 7, F_PERR,  1, "finrun_perr_set");
    expect_at(1, 7, F_STATE, 0, "finrun_still_run");
    for (int r = 0; r < 9; r++) begin
      drive(1, 0, 0, r == 6, 0, 0, 0, 0, 0, (r <= 4) ? 2'd2 : 2'd0, 2'd0);
      tick();
    end

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
